// File: rtl/snn_pkg.sv
// Shared SNN datapath constants, phase encoding and saturating arithmetic.
package snn_pkg;
  localparam int N_HIDDEN = 40;
  localparam int VOL_W    = 16;
  localparam int W_W      = 8;
  localparam int CNT_W    = 3;
  localparam int ADDR_W   = 6;

  localparam logic signed [VOL_W-1:0] THRESHOLD_DEF = 16'sd256;

  typedef enum logic [1:0] {
    PH_IDLE        = 2'd0,
    PH_ACCUM       = 2'd1,
    PH_EXPORT_WAIT = 2'd2
  } phase_e;

  // Sum is formed one bit wider so overflow shows up as a sign disagreement.
  function automatic logic signed [VOL_W-1:0] sat_add(
    input logic signed [VOL_W-1:0] a,
    input logic signed [VOL_W-1:0] b
  );
    logic signed [VOL_W:0] s;
    s = {a[VOL_W-1], a} + {b[VOL_W-1], b};
    if (s[VOL_W] != s[VOL_W-1])
      sat_add = s[VOL_W] ? {1'b1, {(VOL_W-1){1'b0}}} : {1'b0, {(VOL_W-1){1'b1}}};
    else
      sat_add = s[VOL_W-1:0];
  endfunction

  function automatic logic signed [VOL_W-1:0] sext_w(input logic signed [W_W-1:0] w);
    sext_w = {{(VOL_W-W_W){w[W_W-1]}}, w};
  endfunction
endpackage

// File: rtl/hidden_neuron_datapath_if.sv
// Controller-to-datapath command strobes plus spike/count results.
interface hidden_neuron_datapath_if;
  import snn_pkg::*;

  logic [ADDR_W-1:0]         neuron_addr;
  logic                      vol_mem_control;
  logic [VOL_W-1:0]          init_mem_vol;
  logic                      load_voltage;
  logic                      arithm;
  logic                      w_n_a_valid;
  logic [W_W-1:0]            weight_in;
  logic                      act_in;
  logic                      export_voltage;
  logic                      current_step_finished;
  logic                      spike_out;
  logic [ADDR_W-1:0]         spike_idx;
  logic                      spike_valid;
  logic [N_HIDDEN*CNT_W-1:0] counts_bus;
  logic                      counts_valid;

  modport master (
    output neuron_addr, vol_mem_control, init_mem_vol, load_voltage, arithm,
           w_n_a_valid, weight_in, act_in, export_voltage, current_step_finished,
    input  spike_out, spike_idx, spike_valid, counts_bus, counts_valid
  );

  modport slave (
    input  neuron_addr, vol_mem_control, init_mem_vol, load_voltage, arithm,
           w_n_a_valid, weight_in, act_in, export_voltage, current_step_finished,
    output spike_out, spike_idx, spike_valid, counts_bus, counts_valid
  );
endinterface

// File: rtl/hidden_neuron_datapath_lif_update.sv
// LIF integrate/fire/subtract-reset, purely combinational.
module lif_update
  import snn_pkg::*;
(
  input  logic signed [VOL_W-1:0] acc_v,
  input  logic signed [VOL_W-1:0] acc_cur,
  input  logic signed [VOL_W-1:0] threshold,
  output logic signed [VOL_W-1:0] v_next,
  output logic                    fire
);
  logic signed [VOL_W-1:0] v_new;

  always_comb begin
    v_new  = sat_add(acc_v, acc_cur);
    fire   = (v_new >= threshold);
    // With a positive threshold, v_new >= threshold keeps the subtraction in range.
    v_next = fire ? (v_new - threshold) : v_new;
  end
endmodule

// File: rtl/hidden_neuron_datapath.sv
// Hidden-layer membrane datapath: accumulate current, integrate, fire, count spikes.
// Load/weight take effect next cycle; export writes memories at its edge and pulses spike_valid for one cycle.
module hidden_neuron_datapath
  import snn_pkg::*;
#(
  parameter logic signed [VOL_W-1:0] THRESHOLD = THRESHOLD_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hidden_neuron_datapath_if.slave nif
);
  logic signed [VOL_W-1:0] vmem [N_HIDDEN];
  logic signed [VOL_W-1:0] imem [N_HIDDEN];
  logic [CNT_W-1:0]        cnt  [N_HIDDEN];
  logic [CNT_W-1:0]        cnt_post [N_HIDDEN];

  logic signed [VOL_W-1:0] acc_v, acc_cur;
  logic [ADDR_W-1:0]       addr_q, rd_idx;
  logic signed [VOL_W-1:0] rd_v, rd_i, v_next;
  logic                    fire, addr_ok, addr_q_ok;
  logic                    init_cmd, load_cmd, wna_cmd, exp_ok, fin_cmd;

  logic                      spike_out_q, spike_valid_q, counts_valid_q;
  logic [ADDR_W-1:0]         spike_idx_q;
  logic [N_HIDDEN*CNT_W-1:0] counts_q, counts_nxt;

  phase_e phase_q, phase_d;

  // Init owns the cycle: every other strobe is suppressed while it is high.
  always_comb begin
    init_cmd  = nif.vol_mem_control;
    addr_ok   = (nif.neuron_addr < ADDR_W'(N_HIDDEN));
    addr_q_ok = (addr_q < ADDR_W'(N_HIDDEN));
    load_cmd  = nif.load_voltage & ~init_cmd;
    wna_cmd   = nif.w_n_a_valid & nif.act_in & ~nif.arithm & ~nif.load_voltage & ~init_cmd;
    exp_ok    = nif.export_voltage & ~init_cmd & addr_q_ok;
    fin_cmd   = nif.current_step_finished & ~init_cmd;
    rd_idx    = addr_ok ? nif.neuron_addr : '0;
    rd_v      = addr_ok ? vmem[rd_idx] : '0;
    rd_i      = addr_ok ? imem[rd_idx] : '0;
  end

  lif_update u_lif (
    .acc_v     (acc_v),
    .acc_cur   (acc_cur),
    .threshold (THRESHOLD),
    .v_next    (v_next),
    .fire      (fire)
  );

  // Counts as they stand after this cycle's export, so a coincident finish sees the increment.
  always_comb begin
    for (int i = 0; i < N_HIDDEN; i++) cnt_post[i] = cnt[i];
    if (exp_ok && fire && (cnt[addr_q] != '1))
      cnt_post[addr_q] = cnt[addr_q] + CNT_W'(1);
    counts_nxt = '0;
    for (int i = 0; i < N_HIDDEN; i++) counts_nxt[i*CNT_W +: CNT_W] = cnt_post[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_HIDDEN; i++) begin
        vmem[i] <= '0;
        imem[i] <= '0;
        cnt[i]  <= '0;
      end
      acc_v          <= '0;
      acc_cur        <= '0;
      addr_q         <= '0;
      spike_out_q    <= 1'b0;
      spike_idx_q    <= '0;
      spike_valid_q  <= 1'b0;
      counts_q       <= '0;
      counts_valid_q <= 1'b0;
    end else begin
      if (init_cmd && addr_ok) begin
        vmem[rd_idx] <= nif.init_mem_vol;
        imem[rd_idx] <= '0;
      end
      if (exp_ok) begin
        vmem[addr_q] <= v_next;
        if (!nif.arithm) imem[addr_q] <= acc_cur;
      end
      for (int i = 0; i < N_HIDDEN; i++) cnt[i] <= fin_cmd ? '0 : cnt_post[i];

      if (load_cmd) begin
        addr_q  <= nif.neuron_addr;
        acc_v   <= rd_v;
        acc_cur <= nif.arithm ? rd_i : '0;
      end else if (wna_cmd) begin
        acc_cur <= sat_add(acc_cur, sext_w(nif.weight_in));
      end

      spike_valid_q <= exp_ok;
      if (exp_ok) begin
        spike_out_q <= fire;
        spike_idx_q <= addr_q;
      end
      counts_valid_q <= fin_cmd;
      if (fin_cmd) counts_q <= counts_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= PH_IDLE;
    else        phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (load_cmd)                         phase_d = PH_ACCUM;
    else if (nif.export_voltage && !init_cmd) phase_d = PH_EXPORT_WAIT;
    else if (fin_cmd)                     phase_d = PH_IDLE;
  end

  assign nif.spike_out    = spike_out_q;
  assign nif.spike_idx    = spike_idx_q;
  assign nif.spike_valid  = spike_valid_q;
  assign nif.counts_bus   = counts_q;
  assign nif.counts_valid = counts_valid_q;
endmodule

// File: tb/tb_hidden_neuron_datapath.sv
// Randomized and directed bench for hidden_neuron_datapath against a transaction-level model.
module tb_hidden_neuron_datapath;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hidden_neuron_datapath_if nif();
  hidden_neuron_datapath dut (.clk(clk), .rst_n(rst_n), .nif(nif));

  int n_checks = 0;
  int n_fail   = 0;

  int m_vmem [N_HIDDEN];
  int m_imem [N_HIDDEN];
  int m_cnt  [N_HIDDEN];
  int m_acc_v, m_acc_cur, m_addr;
  bit m_arithm;

  logic [N_HIDDEN*CNT_W-1:0] exp_counts, obs_counts;
  logic obs_valid, obs_spike, obs_cvalid;
  logic [5:0] obs_idx;
  bit exp_valid, exp_spike;
  int exp_idx;

  function automatic int clamp(int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < N_HIDDEN; i++)
      if (dut.vmem[i] !== 16'(m_vmem[i]) || dut.imem[i] !== 16'(m_imem[i]) || dut.cnt[i] !== 3'(m_cnt[i]))
        n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_HIDDEN; i++) begin
      m_vmem[i] = 0; m_imem[i] = 0; m_cnt[i] = 0;
    end
    m_acc_v = 0; m_acc_cur = 0; m_addr = 0;
  endtask

  task automatic pack_counts();
    exp_counts = '0;
    for (int i = 0; i < N_HIDDEN; i++) exp_counts[i*CNT_W +: CNT_W] = 3'(m_cnt[i]);
    for (int i = 0; i < N_HIDDEN; i++) m_cnt[i] = 0;
  endtask

  task automatic clear_cmds();
    nif.vol_mem_control = 0; nif.load_voltage = 0; nif.w_n_a_valid = 0;
    nif.act_in = 0; nif.export_voltage = 0; nif.current_step_finished = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_init(int a, int v);
    nif.neuron_addr = 6'(a); nif.init_mem_vol = 16'(v); nif.vol_mem_control = 1;
    tick(); clear_cmds();
    if (a < N_HIDDEN) begin m_vmem[a] = clamp(v); m_imem[a] = 0; end
  endtask

  task automatic model_load(int a, bit ar);
    m_addr = a; m_arithm = ar;
    m_acc_v = (a < N_HIDDEN) ? m_vmem[a] : 0;
    m_acc_cur = (ar && a < N_HIDDEN) ? m_imem[a] : 0;
  endtask

  task automatic do_load(int a, bit ar);
    nif.neuron_addr = 6'(a); nif.arithm = ar; nif.load_voltage = 1;
    tick(); clear_cmds();
    model_load(a, ar);
  endtask

  task automatic do_weight(int w, bit act);
    nif.weight_in = 8'(w); nif.act_in = act; nif.w_n_a_valid = 1;
    tick(); clear_cmds();
    if (act && !m_arithm) m_acc_cur = clamp(m_acc_cur + w);
  endtask

  task automatic do_export(bit fin, bit ld, int ld_addr, bit ld_ar);
    int v;
    bit ar_now;
    ar_now = ld ? ld_ar : m_arithm;
    nif.export_voltage = 1; nif.current_step_finished = fin;
    if (ld) begin nif.load_voltage = 1; nif.neuron_addr = 6'(ld_addr); nif.arithm = ld_ar; end
    tick();
    obs_valid = nif.spike_valid; obs_spike = nif.spike_out; obs_idx = nif.spike_idx;
    obs_cvalid = nif.counts_valid; obs_counts = nif.counts_bus;
    clear_cmds();
    v = clamp(m_acc_v + m_acc_cur);
    exp_valid = (m_addr < N_HIDDEN); exp_spike = (v >= 256); exp_idx = m_addr;
    if (m_addr < N_HIDDEN) begin
      m_vmem[m_addr] = exp_spike ? v - 256 : v;
      if (!ar_now) m_imem[m_addr] = m_acc_cur;
      if (exp_spike && m_cnt[m_addr] < 7) m_cnt[m_addr]++;
    end
    if (fin) pack_counts();
    if (ld) model_load(ld_addr, ld_ar);
  endtask

  task automatic do_finish();
    nif.current_step_finished = 1;
    tick();
    obs_cvalid = nif.counts_valid; obs_counts = nif.counts_bus;
    clear_cmds();
    pack_counts();
  endtask

  task automatic test_reset();
    rst_n = 0; clear_cmds(); nif.arithm = 0; nif.neuron_addr = '0;
    nif.init_mem_vol = '0; nif.weight_in = '0;
    model_reset();
    tick(); tick();
    n_checks++;
    if ({nif.spike_out, nif.spike_idx, nif.spike_valid, nif.counts_valid} !== 9'd0 || nif.counts_bus !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got so=%b idx=%0d sv=%b cv=%b bus=%h, need all 0",
        nif.spike_out, nif.spike_idx, nif.spike_valid, nif.counts_valid, nif.counts_bus);
    end
    n_checks++;
    if (mem_diffs() != 0 || dut.acc_v !== 16'sd0 || dut.acc_cur !== 16'sd0) begin
      n_fail++; $display("FAIL reset_state: %0d entries differ, acc_v=%0d acc_cur=%0d, need 0", mem_diffs(), dut.acc_v, dut.acc_cur);
    end
    rst_n = 1; tick();
  endtask

  task automatic test_init();
    int bad = 0;
    for (int i = 0; i < N_HIDDEN; i++) do_init(i, 63);
    for (int i = 0; i < N_HIDDEN; i++) if (dut.vmem[i] !== 16'sd63 || dut.imem[i] !== 16'sd0) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL init_all: %0d entries not vmem=63/imem=0, need 0", bad); end
    n_checks++;
    if (nif.spike_valid !== 1'b0 || nif.counts_valid !== 1'b0 || nif.counts_bus !== '0) begin
      n_fail++; $display("FAIL init_outputs: sv=%b cv=%b, need 0", nif.spike_valid, nif.counts_valid);
    end
  endtask

  task automatic test_step_sequence();
    do_load(5, 0);
    do_weight(100, 1); do_weight(120, 1); do_weight(-20, 1); do_weight(50, 0);
    do_export(0, 0, 0, 0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_spike !== 1'b1 || obs_idx !== 6'd5 || dut.vmem[5] !== 16'sd7 || dut.imem[5] !== 16'sd200) begin
      n_fail++; $display("FAIL step0: sv=%b so=%b idx=%0d vmem=%0d imem=%0d, need 1 1 5 7 200",
        obs_valid, obs_spike, obs_idx, dut.vmem[5], dut.imem[5]);
    end
    tick();
    n_checks++;
    if (nif.spike_valid !== 1'b0) begin n_fail++; $display("FAIL spike_pulse_width: sv=%b, need 0", nif.spike_valid); end
    do_load(5, 1); do_export(0, 0, 0, 0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_spike !== 1'b0 || dut.vmem[5] !== 16'sd207) begin
      n_fail++; $display("FAIL step1: sv=%b so=%b vmem=%0d, need 1 0 207", obs_valid, obs_spike, dut.vmem[5]);
    end
    do_load(5, 1); do_export(0, 0, 0, 0);
    n_checks++;
    if (obs_spike !== 1'b1 || dut.vmem[5] !== 16'sd151 || dut.imem[5] !== 16'sd200) begin
      n_fail++; $display("FAIL step2: so=%b vmem=%0d imem=%0d, need 1 151 200", obs_spike, dut.vmem[5], dut.imem[5]);
    end
  endtask

  task automatic test_saturation();
    do_init(10, 32700); do_load(10, 0); do_weight(100, 1); do_weight(100, 1);
    do_export(0, 0, 0, 0);
    n_checks++;
    if (obs_spike !== 1'b1 || dut.vmem[10] !== 16'sd32511) begin
      n_fail++; $display("FAIL sat_pos: so=%b vmem=%0d, need 1 32511", obs_spike, dut.vmem[10]);
    end
    do_init(11, 0); do_load(11, 0);
    repeat (313) do_weight(-128, 1);
    n_checks++;
    if (dut.acc_cur !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg_acc: acc_cur=%0d, need -32768", dut.acc_cur); end
    do_export(0, 0, 0, 0);
    n_checks++;
    if (obs_spike !== 1'b0 || dut.vmem[11] !== -16'sd32768 || dut.imem[11] !== -16'sd32768) begin
      n_fail++; $display("FAIL sat_neg: so=%b vmem=%0d imem=%0d, need 0 -32768 -32768", obs_spike, dut.vmem[11], dut.imem[11]);
    end
  endtask

  task automatic test_counts();
    int bad = 0;
    do_finish();
    n_checks++;
    if (obs_cvalid !== 1'b1) begin n_fail++; $display("FAIL counts_pulse_pre: cv=%b, need 1", obs_cvalid); end
    do_init(0, 300); do_init(39, 0);
    for (int s = 0; s < 4; s++) begin
      do_load(39, s != 0); do_export(0, 0, 0, 0);
      do_load(0, s != 0);
      if (s == 0) repeat (3) do_weight(127, 1);
      do_export(s == 3, 0, 0, 0);
    end
    n_checks++;
    if (obs_cvalid !== 1'b1 || obs_counts[2:0] !== 3'd4 || obs_counts[119:117] !== 3'd0 || obs_counts !== exp_counts) begin
      n_fail++; $display("FAIL counts_final: cv=%b bus=%h, need 1 %h (field0=4, field39=0)", obs_cvalid, obs_counts, exp_counts);
    end
    tick();
    for (int i = 0; i < N_HIDDEN; i++) if (dut.cnt[i] !== 3'd0) bad++;
    n_checks++;
    if (nif.counts_valid !== 1'b0 || nif.counts_bus !== exp_counts || bad != 0) begin
      n_fail++; $display("FAIL counts_hold: cv=%b bus=%h nonzero_cnt=%0d, need 0 %h 0", nif.counts_valid, nif.counts_bus, bad, exp_counts);
    end
  endtask

  task automatic test_load_export_same();
    do_init(3, 200); do_init(4, 100);
    do_load(3, 0); do_weight(80, 1);
    do_export(0, 1, 4, 0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_idx !== 6'd3 || obs_spike !== 1'b1 || dut.vmem[3] !== 16'sd24 || dut.imem[3] !== 16'sd80) begin
      n_fail++; $display("FAIL load_export_old: idx=%0d so=%b vmem=%0d imem=%0d, need 3 1 24 80", obs_idx, obs_spike, dut.vmem[3], dut.imem[3]);
    end
    do_weight(10, 1); do_export(0, 0, 0, 0);
    n_checks++;
    if (obs_idx !== 6'd4 || obs_spike !== 1'b0 || dut.vmem[4] !== 16'sd110) begin
      n_fail++; $display("FAIL load_export_new: idx=%0d so=%b vmem=%0d, need 4 0 110", obs_idx, obs_spike, dut.vmem[4]);
    end
  endtask

  task automatic test_out_of_range();
    do_init(45, 999);
    do_load(50, 0);
    n_checks++;
    if (dut.acc_v !== 16'sd0 || dut.addr_q !== 6'd50) begin
      n_fail++; $display("FAIL oor_load: acc_v=%0d addr_q=%0d, need 0 50", dut.acc_v, dut.addr_q);
    end
    do_weight(100, 1); do_export(0, 0, 0, 0);
    n_checks++;
    if (obs_valid !== 1'b0 || mem_diffs() != 0) begin
      n_fail++; $display("FAIL oor_export: sv=%b diffs=%0d, need 0 0", obs_valid, mem_diffs());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int a, nw;
      bit ar;
      if ($urandom_range(0, 3) == 0) do_init($urandom_range(0, 39), int'($urandom_range(0, 1200)) - 600);
      a = $urandom_range(0, 39); ar = 1'($urandom_range(0, 1)); nw = $urandom_range(0, 5);
      do_load(a, ar);
      for (int k = 0; k < nw; k++) do_weight(int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
      do_export(it % 20 == 19, 0, 0, 0);
      n_checks++;
      if (obs_valid !== exp_valid || obs_spike !== exp_spike || obs_idx !== 6'(exp_idx)) begin
        n_fail++; $display("FAIL rand_spike it=%0d: sv=%b so=%b idx=%0d, need %b %b %0d", it, obs_valid, obs_spike, obs_idx, exp_valid, exp_spike, exp_idx);
      end
      if (it % 20 == 19) begin
        n_checks++;
        if (obs_cvalid !== 1'b1 || obs_counts !== exp_counts) begin
          n_fail++; $display("FAIL rand_counts it=%0d: cv=%b bus=%h, need 1 %h", it, obs_cvalid, obs_counts, exp_counts);
        end
      end
    end
    n_checks++;
    if (mem_diffs() != 0) begin n_fail++; $display("FAIL rand_mem: %0d entries differ, need 0", mem_diffs()); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_init(7, 500); do_load(7, 0); do_weight(100, 1);
    #2 rst_n = 0; model_reset(); #1;
    n_checks++;
    if (dut.acc_cur !== 16'sd0 || dut.acc_v !== 16'sd0 || nif.spike_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_acc: acc_v=%0d acc_cur=%0d sv=%b, need 0 0 0", dut.acc_v, dut.acc_cur, nif.spike_valid);
    end
    tick(); rst_n = 1;
    for (int c = 0; c < 3; c++) begin tick(); if (nif.spike_valid !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0 || mem_diffs() != 0 || nif.counts_bus !== '0) begin
      n_fail++; $display("FAIL reset_mid_state: sv_cycles=%0d diffs=%0d bus=%h, need 0 0 0", bad, mem_diffs(), nif.counts_bus);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_step_sequence();
    test_saturation();
    test_counts();
    test_load_export_same();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hidden_neuron_datapath.md
# hidden_neuron_datapath

Membrane-voltage datapath for the 40 hidden LIF neurons of the bin-ratio ensemble SNN. It sits directly downstream of the controller state machine and consumes its command strobes: voltage-memory init, voltage load, weight-and-activation valid, accumulate mode and voltage export. It accumulates synaptic current, integrates it into membrane voltage, applies threshold and subtract-reset, and emits per-export spikes. It also emits per-neuron spike counts after the final time step.

## Interface
- N_HIDDEN, 40, number of hidden neurons / memory depth
- VOL_W, 16, signed membrane-voltage and current width
- W_W, 8, signed weight width
- THRESHOLD, 256, firing threshold (signed, VOL_W bits)
- CNT_W, 3, per-neuron spike-count width (4 time steps max)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- neuron_addr  in  6  hidden-neuron index (controller offset address)
- vol_mem_control  in  1  init write strobe
- init_mem_vol  in  16  init voltage value
- load_voltage  in  1  load neuron state into accumulators
- arithm  in  1  0 = weighted-sum step (time step 0), 1 = re-accumulate stored current
- w_n_a_valid  in  1  weight/activation pair valid
- weight_in  in  W_W  signed synaptic weight
- act_in  in  1  input spike for this weight
- export_voltage  in  1  integrate, fire, write back
- current_step_finished  in  1  all time steps done
- spike_out  out  1  spike result of last export
- spike_idx  out  6  neuron index of last export
- spike_valid  out  1  one-cycle pulse, spike_out/spike_idx valid
- counts_bus  out  N_HIDDEN*CNT_W  packed spike counts, neuron 0 in LSBs
- counts_valid  out  1  one-cycle pulse, counts_bus updated

## Operation
- State: vmem[40] and imem[40] (VOL_W signed), acc_v, acc_cur, addr_q, cnt[40]. Phase register: IDLE, ACCUM, EXPORT_WAIT; the phase is informational only and never blocks a command.
- vol_mem_control: vmem[neuron_addr] <= init_mem_vol; imem[neuron_addr] <= 0. Takes priority over every other strobe in the same cycle.
- load_voltage: addr_q <= neuron_addr; acc_v <= vmem[neuron_addr]. If arithm=0, acc_cur <= 0. If arithm=1, acc_cur <= imem[neuron_addr]. Phase becomes ACCUM.
- w_n_a_valid with arithm=0 and act_in=1: acc_cur <= sat(acc_cur + sext(weight_in)). With act_in=0 nothing changes.
- w_n_a_valid in the same cycle as load_voltage, or with arithm=1: ignored. The accumulator is loaded, not summed.
- export_voltage: v_new = sat(acc_v + acc_cur).
  - If v_new >= THRESHOLD: fire; vmem[addr_q] <= v_new - THRESHOLD; cnt[addr_q] <= cnt+1, saturating at 7.
  - Otherwise: vmem[addr_q] <= v_new.
  - If arithm=0: imem[addr_q] <= acc_cur.
  - Export uses addr_q, never neuron_addr.
- current_step_finished: counts_bus <= cnt; all cnt <= 0; counts_valid pulses.
- sat(): clamp to [-32768, 32767]. Every sum is computed VOL_W+1 bits wide.
- neuron_addr >= 40: writes dropped; reads return 0; addr_q still latches, so a later export is dropped.
- Reset: every memory entry, accumulator and counter = 0. spike_out=0, spike_idx=0, spike_valid=0, counts_bus=0, counts_valid=0. A reset mid-step discards all partial sums.

## Timing
- Memories are register files with combinational read and synchronous write.
- load_voltage at edge t → acc_v/acc_cur valid from t+1.
- w_n_a_valid at edge t → acc_cur updated at t+1, one pair per cycle, back-to-back allowed.
- export at edge t → vmem/imem/cnt updated at t; spike_out, spike_idx, spike_valid asserted for cycle t+1 only.
- load_voltage and export_voltage in the same cycle: export uses the old accumulators and old addr_q; the load then takes effect.
- current_step_finished coincident with export: the export's count increment is included in counts_bus.
- counts_valid: one cycle after the strobe; counts_bus holds until the next strobe.

## Structure
- Shared package snn_pkg: N_HIDDEN, VOL_W, W_W, CNT_W, the saturating-add function, and the phase enum constants.
- One sub-module, lif_update: combinational block with inputs acc_v, acc_cur, THRESHOLD and outputs v_next, fire. It is reused by the output-layer datapath.

## Test plan
- Reset, then 40 init writes of 63 → every vmem = 63, every imem = 0, all outputs 0.
- Step 0, neuron 5: load; weights +100, +120, -20 with act 1,1,1; weight +50 with act 0; export → v_new = 263, spike_out=1, spike_idx=5, vmem[5]=7, imem[5]=200.
- Step 1, neuron 5 (arithm=1): load then export → v_new = 207, no spike, vmem[5]=207. Step 2 → 407, fire, vmem=151.
- Saturation: vmem=32700, acc_cur=+200 → vmem = 32767-256 after fire. Negative path: weights summing to -40000 → clamps to -32768.
- 4 steps with neuron 0 firing every step and neuron 39 never, then finish strobe → counts_valid pulse; counts_bus[2:0]=4, top field 0; internal cnt cleared.
- rst_n asserted between a load and its export → no spike_valid; all state 0 after release.
